// File: rtl/dfd_tn_pkg.sv
// Shared trace-network definitions.
// Holds the source encodings for trace messages and the default layout of a
// buffered {src, data} entry. The default entry is sized for a 16-byte message.
// Blocks with another payload width build an entry with the same field order.
package dfd_tn_pkg;

  typedef enum logic {
    TN_SRC_NTRACE = 1'b0,
    TN_SRC_DST    = 1'b1
  } tn_src_e;

  localparam int TN_DATA_WIDTH = 128;

  typedef struct packed {
    tn_src_e                  src;
    logic [TN_DATA_WIDTH-1:0] data;
  } tn_entry_t;

endpackage

// File: rtl/dfd_tn_msg_fifo.sv
// In-order message FIFO for the trace message-send buffer.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset (empties the FIFO)
//   push, push_entry: write push_entry at the tail (caller guarantees !full | pop)
//   pop             : retire the head entry (caller guarantees !empty)
//   full, empty     : occupancy flags from pointers with an extra wrap bit
//   head            : entry at the read pointer (only meaningful when !empty)
module dfd_tn_msg_fifo
  import dfd_tn_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = tn_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rd_ptr_q, rd_ptr_d;

  // Push and pop on a full FIFO write the slot being vacated by the pop;
  // the head is read from mem_q, so the outgoing entry is still presented.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PW-1:0]] = push_entry;
      wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head  = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/dfd_trace_ms_buffer.sv
// Trace message-send buffer between the trace encoder and the trace network.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   enc_vld/enc_src/enc_data   : message offered by the encoder
//   enc_rdy                    : buffer takes the offered message this cycle
//   MS_TN_Vld/Src/Data         : head message presented to the network
//   TN_MS_Gnt                  : network takes the presented message
//   TN_MS_Ntrace_Bp/Dst_Bp     : per-source backpressure (hides the head)
//   TN_MS_Ntrace_Flush/Dst_Flush : drain request; new messages of that
//                                 source are refused while asserted
//   ntrace_flush_done/dst_flush_done : drain request seen and none held
//   drop_cnt                   : saturating count of refused offers
//
// Handshakes: a transfer happens on a cycle where valid and ready/grant are
// both high at the clock edge. enc_rdy may depend on TN_MS_Gnt in the same
// cycle (a full buffer accepts when its head leaves). MS_TN_Vld never depends
// on TN_MS_Gnt; a grant without valid is ignored. An offer that sees
// enc_rdy=0 is dropped and counted, not retried by the buffer.
module dfd_trace_ms_buffer
  import dfd_tn_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int DATA_WIDTH          = DATA_WIDTH_IN_BYTES * 8,
  parameter int FIFO_DEPTH          = 4,
  parameter int DROP_CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enc_vld,
  input  logic                      enc_src,
  input  logic [DATA_WIDTH-1:0]     enc_data,
  output logic                      enc_rdy,
  output logic                      MS_TN_Vld,
  output logic                      MS_TN_Src,
  output logic [DATA_WIDTH-1:0]     MS_TN_Data,
  input  logic                      TN_MS_Gnt,
  input  logic                      TN_MS_Ntrace_Bp,
  input  logic                      TN_MS_Dst_Bp,
  input  logic                      TN_MS_Ntrace_Flush,
  input  logic                      TN_MS_Dst_Flush,
  output logic                      ntrace_flush_done,
  output logic                      dst_flush_done,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Same field order as tn_entry_t, sized to this instance's payload.
  typedef struct packed {
    tn_src_e               src;
    logic [DATA_WIDTH-1:0] data;
  } msg_t;

  msg_t    push_entry;
  msg_t    head;
  tn_src_e in_src;
  logic    full, empty, push, pop;
  logic    flush_block, head_bp;

  logic [CW-1:0]             ntrace_cnt_q, ntrace_cnt_d;
  logic [CW-1:0]             dst_cnt_q, dst_cnt_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  dfd_tn_msg_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (msg_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head       (head)
  );

  always_comb begin
    in_src          = tn_src_e'(enc_src);
    push_entry.src  = in_src;
    push_entry.data = enc_data;

    flush_block = (TN_MS_Ntrace_Flush && (in_src == TN_SRC_NTRACE)) ||
                  (TN_MS_Dst_Flush    && (in_src == TN_SRC_DST));

    // Backpressure only hides the head; it never lets a younger entry pass.
    head_bp   = (head.src == TN_SRC_DST) ? TN_MS_Dst_Bp : TN_MS_Ntrace_Bp;
    MS_TN_Vld = !empty && !head_bp;
    pop       = MS_TN_Vld && TN_MS_Gnt;
    enc_rdy   = (!full || pop) && !flush_block;
    push      = enc_vld && enc_rdy;

    MS_TN_Src  = empty ? 1'b0 : logic'(head.src);
    MS_TN_Data = empty ? '0 : head.data;

    ntrace_cnt_d = ntrace_cnt_q;
    dst_cnt_d    = dst_cnt_q;
    if (push && (in_src == TN_SRC_NTRACE)) ntrace_cnt_d = ntrace_cnt_d + CW'(1);
    if (pop  && (head.src == TN_SRC_NTRACE)) ntrace_cnt_d = ntrace_cnt_d - CW'(1);
    if (push && (in_src == TN_SRC_DST)) dst_cnt_d = dst_cnt_d + CW'(1);
    if (pop  && (head.src == TN_SRC_DST)) dst_cnt_d = dst_cnt_d - CW'(1);

    drop_cnt_d = drop_cnt_q;
    if (enc_vld && !enc_rdy && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end

    ntrace_flush_done = TN_MS_Ntrace_Flush && (ntrace_cnt_q == '0);
    dst_flush_done    = TN_MS_Dst_Flush    && (dst_cnt_q == '0);
    drop_cnt          = drop_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ntrace_cnt_q <= '0;
      dst_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      ntrace_cnt_q <= ntrace_cnt_d;
      dst_cnt_q    <= dst_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_dfd_trace_ms_buffer.sv
// Bench for dfd_trace_ms_buffer: directed steps plus a random phase, each
// cycle compared against a queue model of the buffer. The drop counter is
// narrowed to 4 bits so its saturation point is reachable quickly.
module tb_dfd_trace_ms_buffer;

  localparam int DW    = 128;
  localparam int DEPTH = 4;
  localparam int DCW   = 4;
  localparam int DMAX  = (1 << DCW) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           enc_vld, enc_src, enc_rdy;
  logic [DW-1:0]  enc_data;
  logic           MS_TN_Vld, MS_TN_Src;
  logic [DW-1:0]  MS_TN_Data;
  logic           TN_MS_Gnt, TN_MS_Ntrace_Bp, TN_MS_Dst_Bp;
  logic           TN_MS_Ntrace_Flush, TN_MS_Dst_Flush;
  logic           ntrace_flush_done, dst_flush_done;
  logic [DCW-1:0] drop_cnt;

  dfd_trace_ms_buffer #(
    .DATA_WIDTH_IN_BYTES (16),
    .FIFO_DEPTH          (DEPTH),
    .DROP_CNT_WIDTH      (DCW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enc_vld            (enc_vld),
    .enc_src            (enc_src),
    .enc_data           (enc_data),
    .enc_rdy            (enc_rdy),
    .MS_TN_Vld          (MS_TN_Vld),
    .MS_TN_Src          (MS_TN_Src),
    .MS_TN_Data         (MS_TN_Data),
    .TN_MS_Gnt          (TN_MS_Gnt),
    .TN_MS_Ntrace_Bp    (TN_MS_Ntrace_Bp),
    .TN_MS_Dst_Bp       (TN_MS_Dst_Bp),
    .TN_MS_Ntrace_Flush (TN_MS_Ntrace_Flush),
    .TN_MS_Dst_Flush    (TN_MS_Dst_Flush),
    .ntrace_flush_done  (ntrace_flush_done),
    .dst_flush_done     (dst_flush_done),
    .drop_cnt           (drop_cnt)
  );

  // scoreboard: held messages as {src, data}, oldest first
  logic [DW:0] exp_q[$];
  int          drop_exp;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int held(input logic s);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][DW] == s) n++;
    return n;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic s, input logic [DW-1:0] d, input logic g);
    enc_vld   = v;
    enc_src   = s;
    enc_data  = d;
    TN_MS_Gnt = g;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at posedge+1 with inputs driven: compares all outputs with the
  // model, advances one clock and applies the expected transfers.
  task automatic cycle(input string tag);
    logic          hsrc, m_vld, m_pop, m_blk, m_rdy;
    logic [DW-1:0] hdata;
    #1;
    hsrc  = (exp_q.size() != 0) ? exp_q[0][DW] : 1'b0;
    hdata = (exp_q.size() != 0) ? exp_q[0][DW-1:0] : '0;
    m_vld = (exp_q.size() != 0) && !(hsrc ? TN_MS_Dst_Bp : TN_MS_Ntrace_Bp);
    m_pop = m_vld && TN_MS_Gnt;
    m_blk = (TN_MS_Ntrace_Flush && !enc_src) || (TN_MS_Dst_Flush && enc_src);
    m_rdy = ((exp_q.size() < DEPTH) || m_pop) && !m_blk;
    chk({tag, ".rdy"},  enc_rdy,    m_rdy);
    chk({tag, ".vld"},  MS_TN_Vld,  m_vld);
    chk({tag, ".src"},  MS_TN_Src,  hsrc);
    chk({tag, ".data"}, MS_TN_Data, hdata);
    chk({tag, ".ndone"}, ntrace_flush_done, TN_MS_Ntrace_Flush && (held(1'b0) == 0));
    chk({tag, ".ddone"}, dst_flush_done,    TN_MS_Dst_Flush    && (held(1'b1) == 0));
    chk({tag, ".drop"}, drop_cnt, drop_exp);
    @(posedge clk);
    if (m_pop) void'(exp_q.pop_front());
    if (enc_vld && m_rdy) exp_q.push_back({enc_src, enc_data});
    if (enc_vld && !m_rdy && drop_exp < DMAX) drop_exp++;
    #1;
  endtask

  initial begin
    // reset state
    reset = 1'b1;
    drive(1'b0, 1'b1, '0, 1'b0);
    TN_MS_Ntrace_Bp = 1'b0; TN_MS_Dst_Bp = 1'b0;
    TN_MS_Ntrace_Flush = 1'b1; TN_MS_Dst_Flush = 1'b0;
    drop_exp = 0;
    #12;
    chk("rst.rdy",   enc_rdy, 1'b1);
    chk("rst.vld",   MS_TN_Vld, 1'b0);
    chk("rst.src",   MS_TN_Src, 1'b0);
    chk("rst.data",  MS_TN_Data, '0);
    chk("rst.ndone", ntrace_flush_done, 1'b1);
    chk("rst.ddone", dst_flush_done, 1'b0);
    chk("rst.drop",  drop_cnt, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    TN_MS_Ntrace_Flush = 1'b0;

    // two messages in order, grant held high
    drive(1'b1, 1'b0, 'hA1, 1'b1); cycle("inord0");
    chk("inord.vld0", MS_TN_Vld, 1'b1);
    chk("inord.data0", MS_TN_Data, 'hA1);
    drive(1'b1, 1'b1, 'hB2, 1'b1); cycle("inord1");
    chk("inord.data1", MS_TN_Data, 'hB2);
    chk("inord.src1", MS_TN_Src, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1); cycle("inord2");
    chk("inord.empty", MS_TN_Vld, 1'b0);

    // fill, refuse a fifth, then push+pop while full
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'(i), rnd_data(), 1'b0); cycle("fill");
    end
    drive(1'b1, 1'b0, rnd_data(), 1'b0); cycle("full.refuse");
    chk("full.drop1", drop_cnt, 1);
    drive(1'b1, 1'b1, rnd_data(), 1'b1); cycle("full.pushpop");
    drive(1'b1, 1'b0, rnd_data(), 1'b0); cycle("full.still");
    chk("full.drop2", drop_cnt, 2);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1); cycle("drain");
    end
    chk("drain.vld", MS_TN_Vld, 1'b0);

    // backpressure on an Ntrace head
    TN_MS_Ntrace_Bp = 1'b1;
    drive(1'b1, 1'b0, 'hC3, 1'b1); cycle("bp.push");
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cycle("bp.hold");
    chk("bp.vld", MS_TN_Vld, 1'b0);
    TN_MS_Ntrace_Bp = 1'b0;
    #1;
    chk("bp.release.vld", MS_TN_Vld, 1'b1);
    chk("bp.release.data", MS_TN_Data, 'hC3);
    cycle("bp.pop");

    // Ntrace flush with two held
    drive(1'b1, 1'b0, rnd_data(), 1'b0); cycle("fl.p0");
    drive(1'b1, 1'b0, rnd_data(), 1'b0); cycle("fl.p1");
    TN_MS_Ntrace_Flush = 1'b1;
    drive(1'b1, 1'b0, rnd_data(), 1'b0); cycle("fl.refuse");
    chk("fl.drop", drop_cnt, 3);
    drive(1'b1, 1'b1, 'hD4, 1'b0); cycle("fl.dst");
    drive(1'b0, 1'b0, '0, 1'b1); cycle("fl.g0"); cycle("fl.g1");
    chk("fl.done", ntrace_flush_done, 1'b1);
    chk("fl.dsthead", MS_TN_Data, 'hD4);
    cycle("fl.g2");
    TN_MS_Ntrace_Flush = 1'b0;

    // random phase
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rnd_data(),
            ($urandom_range(0, 2) != 0));
      TN_MS_Ntrace_Bp    = ($urandom_range(0, 4) == 0);
      TN_MS_Dst_Bp       = ($urandom_range(0, 4) == 0);
      TN_MS_Ntrace_Flush = ($urandom_range(0, 9) == 0);
      TN_MS_Dst_Flush    = ($urandom_range(0, 9) == 0);
      cycle("rnd");
    end

    // drain, hold three, then reset mid-operation
    TN_MS_Ntrace_Bp = 1'b0; TN_MS_Dst_Bp = 1'b0;
    TN_MS_Ntrace_Flush = 1'b0; TN_MS_Dst_Flush = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1); cycle("rdrain");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'(i), rnd_data(), 1'b0); cycle("rfill");
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mrst.vld",  MS_TN_Vld, 1'b0);
    chk("mrst.drop", drop_cnt, '0);
    chk("mrst.rdy",  enc_rdy, 1'b1);
    chk("mrst.data", MS_TN_Data, '0);
    exp_q.delete();
    drop_exp = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    drive(1'b1, 1'b0, 'h5A, 1'b1); cycle("mrst.push");
    chk("mrst.vld1",  MS_TN_Vld, 1'b1);
    chk("mrst.data1", MS_TN_Data, 'h5A);
    drive(1'b0, 1'b0, '0, 1'b1); cycle("mrst.pop");

    // drop counter saturation
    TN_MS_Ntrace_Flush = 1'b1;
    drive(1'b1, 1'b0, rnd_data(), 1'b0);
    for (int i = 0; i < DMAX - 3; i++) cycle("sat.run");
    chk("sat.pre", drop_cnt, DMAX - 3);
    for (int i = 0; i < 3; i++) cycle("sat.top");
    chk("sat.max", drop_cnt, DMAX);
    cycle("sat.hold");
    chk("sat.hold", drop_cnt, DMAX);
    TN_MS_Ntrace_Flush = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
